vdp_dot_timing: RTL and testbench

Master dot/line timing generator for the VDP. It produces the 4-phase DOTSTATE, the 8-dot slot phase and the horizontal/vertical dot counters, which feed vdp_sprite and the other pixel pipelines directly. It also produces the vertical display window, sync strobes and field flag. Display-mode inputs are taken only at frame boundaries so that downstream stages never see a mid-frame geometry change.

---
 rtl/vdp_dot_timing.sv | 206 ++++++++++++++++++++
 tb/tb_vdp_dot_timing.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vdp_dot_timing.sv
// vdp_dot_timing: master dot/line/frame timing for the VDP pixel pipelines.
// Generates the 4-phase dot clock state, the 8-dot slot phase, the X/Y dot
// counters, the vertical display window, sync strobes and the interlace field.
// Display-mode bits are latched only on a frame wrap.
module vdp_dot_timing #(
    parameter logic [8:0] X_FIRST       = 9'h1F8,
    parameter logic [8:0] X_LAST        = 9'd341,
    parameter logic [8:0] Y_LAST_NTSC   = 9'd261,
    parameter logic [8:0] Y_LAST_PAL    = 9'd312,
    parameter logic [8:0] HSYNC_DOTS    = 9'd25,
    parameter logic [8:0] VS_START_NTSC = 9'd234,
    parameter logic [8:0] VS_START_PAL  = 9'd259,
    parameter logic [8:0] VS_LINES      = 9'd3,
    parameter logic [8:0] ACT_LINES_LN0 = 9'd192,
    parameter logic [8:0] ACT_LINES_LN1 = 9'd212
) (
    input  logic       CLK21M,
    input  logic       RESET,
    input  logic       REG_R9_PAL_MODE,
    input  logic       REG_R9_LN,
    input  logic       REG_R9_INTERLACE,
    output logic [1:0] DOTSTATE,
    output logic [2:0] EIGHTDOTSTATE,
    output logic [8:0] DOTCOUNTERX,
    output logic [8:0] DOTCOUNTERYP,
    output logic       BWINDOW_Y,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       FIELD,
    output logic       LINE_START,
    output logic       FRAME_START
);

    // Dot phase sequence 00 -> 01 -> 11 -> 10 (Gray order).
    typedef enum logic [1:0] {
        DS_P0 = 2'b00,
        DS_P1 = 2'b01,
        DS_P2 = 2'b11,
        DS_P3 = 2'b10
    } dot_phase_t;

    dot_phase_t r_phase;
    dot_phase_t w_phase_next;

    logic       w_x_step;
    logic       w_eight_load;

    logic [2:0] r_eight;
    logic [8:0] r_x;
    logic [8:0] r_y;
    logic       r_bwin;
    logic       r_hs_n;
    logic       r_vs_n;
    logic       r_field;
    logic       r_pal;
    logic       r_ln;
    logic       r_il;
    logic       r_line_start;
    logic       r_frame_start;

    logic       w_x_at_last;
    logic [8:0] w_x_next;
    logic [8:0] w_x_off;
    logic [8:0] w_x_next_off;
    logic       w_line_wrap;
    logic [8:0] w_ylast;
    logic       w_y_at_last;
    logic       w_frame_wrap;
    logic [8:0] w_y_next;
    logic       w_pal_next;
    logic       w_ln_next;
    logic       w_il_next;
    logic       w_field_next;
    logic [8:0] w_win_lines;
    logic       w_bwin_next;
    logic [8:0] w_vs_start;
    logic [8:0] w_vs_end;
    logic       w_vs_next_n;
    logic       w_hs_next_n;

    // Dot phase state register.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_phase <= DS_P0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Dot phase next-state: free-running, no enable.
    always_comb begin
        w_phase_next = DS_P0;
        unique case (r_phase)
            DS_P0: w_phase_next = DS_P1;
            DS_P1: w_phase_next = DS_P2;
            DS_P2: w_phase_next = DS_P3;
            DS_P3: w_phase_next = DS_P0;
            default: w_phase_next = DS_P0;
        endcase
    end

    // Dot phase decode: X steps on phase 11, slot phase loads on phase 10.
    always_comb begin
        DOTSTATE     = r_phase;
        w_x_step     = (r_phase == DS_P2);
        w_eight_load = (r_phase == DS_P3);
    end

    // Horizontal / vertical next-value logic and mode latching.
    always_comb begin
        w_x_at_last  = (r_x == X_LAST);
        w_x_next     = w_x_at_last ? X_FIRST : (r_x + 9'd1);
        w_x_off      = r_x - X_FIRST;
        w_x_next_off = w_x_next - X_FIRST;
        w_hs_next_n  = !(w_x_next_off < HSYNC_DOTS);

        w_line_wrap  = w_x_step && w_x_at_last;
        w_ylast      = (r_pal ? Y_LAST_PAL : Y_LAST_NTSC) + {8'd0, (r_il & r_field)};
        w_y_at_last  = (r_y == w_ylast);
        w_frame_wrap = w_line_wrap && w_y_at_last;
        w_y_next     = w_y_at_last ? '0 : (r_y + 9'd1);

        // Window/VSYNC must use the mode that applies to the line being
        // entered, so a frame wrap sees the freshly latched bits.
        w_pal_next   = w_frame_wrap ? REG_R9_PAL_MODE  : r_pal;
        w_ln_next    = w_frame_wrap ? REG_R9_LN        : r_ln;
        w_il_next    = w_frame_wrap ? REG_R9_INTERLACE : r_il;
        w_field_next = w_frame_wrap ? (REG_R9_INTERLACE & ~r_field) : r_field;

        w_win_lines  = w_ln_next ? ACT_LINES_LN1 : ACT_LINES_LN0;
        w_bwin_next  = (w_y_next < w_win_lines);
        w_vs_start   = w_pal_next ? VS_START_PAL : VS_START_NTSC;
        w_vs_end     = w_vs_start + VS_LINES;
        w_vs_next_n  = !((w_y_next >= w_vs_start) && (w_y_next < w_vs_end));
    end

    // Horizontal counter, slot phase and HSYNC.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_x     <= X_FIRST;
            r_eight <= 3'd7;
            r_hs_n  <= 1'b1;
        end else begin
            if (w_x_step) begin
                r_x    <= w_x_next;
                r_hs_n <= w_hs_next_n;
            end
            if (w_eight_load) begin
                r_eight <= w_x_off[2:0];
            end
        end
    end

    // Line counter, vertical window and VSYNC, updated on line wrap.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_y    <= '0;
            r_bwin <= 1'b0;
            r_vs_n <= 1'b1;
        end else if (w_line_wrap) begin
            r_y    <= w_y_next;
            r_bwin <= w_bwin_next;
            r_vs_n <= w_vs_next_n;
        end
    end

    // Mode bits and field flag, updated only on frame wrap.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_pal   <= 1'b0;
            r_ln    <= 1'b0;
            r_il    <= 1'b0;
            r_field <= 1'b0;
        end else begin
            r_pal   <= w_pal_next;
            r_ln    <= w_ln_next;
            r_il    <= w_il_next;
            r_field <= w_field_next;
        end
    end

    // One-clock line/frame start strobes following each wrap edge.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    // Output mapping.
    always_comb begin
        EIGHTDOTSTATE = r_eight;
        DOTCOUNTERX   = r_x;
        DOTCOUNTERYP  = r_y;
        BWINDOW_Y     = r_bwin;
        HSYNC_N       = r_hs_n;
        VSYNC_N       = r_vs_n;
        FIELD         = r_field;
        LINE_START    = r_line_start;
        FRAME_START   = r_frame_start;
    end

endmodule

// File: tb/tb_vdp_dot_timing.sv
// Testbench for vdp_dot_timing with shortened line/frame geometry.
module tb_vdp_dot_timing;

    // Shortened geometry: 32 dots/line (128 clocks), 10/13-line frames.
    localparam int X_FIRST_I = 504;
    localparam int X_LAST_I  = 23;
    localparam int NDOTS     = X_LAST_I - (X_FIRST_I - 512) + 1;
    localparam int YL_NTSC   = 9;
    localparam int YL_PAL    = 12;
    localparam int HS_DOTS   = 5;
    localparam int VS_NTSC   = 6;
    localparam int VS_PAL    = 9;
    localparam int VS_N      = 2;
    localparam int ACT0      = 4;
    localparam int ACT1      = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pal = 1'b0;
    logic       ln  = 1'b0;
    logic       il  = 1'b0;
    logic [1:0] DOTSTATE;
    logic [2:0] EIGHTDOTSTATE;
    logic [8:0] DOTCOUNTERX;
    logic [8:0] DOTCOUNTERYP;
    logic       BWINDOW_Y, HSYNC_N, VSYNC_N, FIELD, LINE_START, FRAME_START;

    vdp_dot_timing #(
        .X_LAST(9'd23), .Y_LAST_NTSC(9'd9), .Y_LAST_PAL(9'd12), .HSYNC_DOTS(9'd5),
        .VS_START_NTSC(9'd6), .VS_START_PAL(9'd9), .VS_LINES(9'd2),
        .ACT_LINES_LN0(9'd4), .ACT_LINES_LN1(9'd7)
    ) dut (
        .CLK21M(clk), .RESET(rst),
        .REG_R9_PAL_MODE(pal), .REG_R9_LN(ln), .REG_R9_INTERLACE(il),
        .DOTSTATE(DOTSTATE), .EIGHTDOTSTATE(EIGHTDOTSTATE),
        .DOTCOUNTERX(DOTCOUNTERX), .DOTCOUNTERYP(DOTCOUNTERYP),
        .BWINDOW_Y(BWINDOW_Y), .HSYNC_N(HSYNC_N), .VSYNC_N(VSYNC_N), .FIELD(FIELD),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: k = clock edges since reset release; per-line events
    // are derived from the dot index d = (k+1)/4.
    int k;
    int my;
    bit mfield, mpal, mln, mil, mbw, mvs_n, mls, mfs;

    task automatic model_reset();
        k = 0; my = 0; mfield = 0; mpal = 0; mln = 0; mil = 0;
        mbw = 0; mvs_n = 1; mls = 0; mfs = 0;
    endtask

    task automatic model_step();
        int ylast;
        int vs;
        k++;
        mls = 0;
        mfs = 0;
        if ((k % 4 == 3) && (((k + 1) / 4) % NDOTS == 0)) begin
            ylast = (mpal ? YL_PAL : YL_NTSC) + ((mil && mfield) ? 1 : 0);
            mls = 1;
            if (my == ylast) begin
                mfs = 1;
                my = 0;
                mpal = pal; mln = ln; mil = il;
                mfield = il ? !mfield : 1'b0;
            end else begin
                my = my + 1;
            end
            mbw = (my < (mln ? ACT1 : ACT0));
            vs = mpal ? VS_PAL : VS_NTSC;
            mvs_n = !((my >= vs) && (my < vs + VS_N));
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        int dm;
        int ds_seq[4];
        ds_seq = '{0, 1, 3, 2};
        #1;
        if (rst) model_reset();
        else model_step();
        dm = ((k + 1) / 4) % NDOTS;
        chk("DOTSTATE", DOTSTATE, ds_seq[k % 4]);
        chk("DOTCOUNTERX", DOTCOUNTERX, (X_FIRST_I + dm) % 512);
        chk("EIGHTDOTSTATE", EIGHTDOTSTATE, (k < 4) ? 7 : (((k / 4) % NDOTS) % 8));
        chk("HSYNC_N", HSYNC_N, (k < 3) ? 1 : ((dm < HS_DOTS) ? 0 : 1));
        chk("DOTCOUNTERYP", DOTCOUNTERYP, my);
        chk("BWINDOW_Y", BWINDOW_Y, mbw);
        chk("VSYNC_N", VSYNC_N, mvs_n);
        chk("FIELD", FIELD, mfield);
        chk("LINE_START", LINE_START, mls);
        chk("FRAME_START", FRAME_START, mfs);
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ds"}, DOTSTATE, 0);
        chk({tag, "_eight"}, EIGHTDOTSTATE, 7);
        chk({tag, "_x"}, DOTCOUNTERX, 9'h1F8);
        chk({tag, "_y"}, DOTCOUNTERYP, 0);
        chk({tag, "_bw"}, BWINDOW_Y, 0);
        chk({tag, "_hs"}, HSYNC_N, 1);
        chk({tag, "_vs"}, VSYNC_N, 1);
        chk({tag, "_field"}, FIELD, 0);
        chk({tag, "_ls"}, LINE_START, 0);
        chk({tag, "_fs"}, FRAME_START, 0);
    endtask

    task automatic wait_pulse(input bit frame, output int at);
        at = -1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (frame ? FRAME_START : LINE_START) begin
                at = cyc;
                return;
            end
        end
        chk(frame ? "frame_start_timeout" : "line_start_timeout", 0, 1);
    endtask

    task automatic mid_line_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t0, t1, n;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // First four phases after release.
        @(posedge clk); #2; chk("e1_ds", DOTSTATE, 1);
        @(posedge clk); #2; chk("e2_ds", DOTSTATE, 3);
        @(posedge clk); #2; chk("e3_ds", DOTSTATE, 2); chk("e3_x", DOTCOUNTERX, 9'h1F9);
        @(posedge clk); #2; chk("e4_ds", DOTSTATE, 0); chk("e4_eight", EIGHTDOTSTATE, 1);

        // Line period and HSYNC width.
        wait_pulse(0, t0);
        wait_pulse(0, t1);
        chk("line_period", t1 - t0, 128);
        chk("hsync_at_wrap", HSYNC_N, 0);
        n = 1;
        for (int i = 0; i < 200 && HSYNC_N == 1'b0; i++) begin
            @(posedge clk); #2;
            if (HSYNC_N == 1'b0) n++;
        end
        chk("hsync_low_clocks", n, 20);

        // NTSC, 192-equivalent window, no interlace.
        wait_pulse(1, t0);
        wait_pulse(1, t1);
        chk("frame_ntsc", t1 - t0, 1280);
        chk("field_ntsc", FIELD, 0);

        // PAL + LN changed mid-frame: takes effect one frame later.
        repeat (640) @(negedge clk);
        pal = 1'b1; ln = 1'b1;
        wait_pulse(1, t0);
        chk("frame_before_pal", t0 - t1, 1280);
        wait_pulse(1, t1);
        chk("frame_pal", t1 - t0, 1664);

        // Interlaced NTSC: alternating 11/10-line frames.
        repeat (640) @(negedge clk);
        pal = 1'b0; ln = 1'b0; il = 1'b1;
        wait_pulse(1, t0);
        chk("frame_pal_tail", t0 - t1, 1664);
        chk("field_first_il", FIELD, 1);
        wait_pulse(1, t1);
        chk("frame_il_odd", t1 - t0, 1408);
        chk("field_second_il", FIELD, 0);
        wait_pulse(1, t0);
        chk("frame_il_even", t0 - t1, 1280);
        chk("field_third_il", FIELD, 1);

        // Mid-line asynchronous reset, then random mode changes and resets.
        repeat (200) @(negedge clk);
        mid_line_reset();
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) mid_line_reset();
            else {pal, ln, il} = 3'($urandom_range(0, 7));
        end
        repeat (3000) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
